stream_rgb888_unpacker: RTL and testbench

STREAM_RGB888_UNPACKER -- requirements
Module: stream_rgb888_unpacker

---
 rtl/stream_rgb888_unpacker.sv | 167 ++++++++++++++++
 tb/tb_stream_rgb888_unpacker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rgb888_unpacker.sv
// Packed RGB888 word stream to one-pixel-per-beat stream.
// Three 32-bit words carry four 24-bit pixels; line/frame marks attached.
module stream_rgb888_unpacker #(
  parameter int LINE_PIXELS = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [23:0] out_pixel,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_sol,
  output logic        out_eol,
  input  logic        out_ready,
  output logic        err_align
);

  localparam int CW = (LINE_PIXELS > 2) ? $clog2(LINE_PIXELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} ph_e;

  ph_e           ph_q, ph_d;
  logic [23:0]   res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eofp_q, eofp_d;
  logic [23:0]   pix_q, pix_d;
  logic          vld_q, vld_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          sol_q, sol_d;
  logic          eol_q, eol_d;
  logic          err_q, err_d;

  logic          ld;
  logic          acc;
  logic          resync;
  ph_e           eph;
  logic          new_px;
  logic          sof_n;
  logic          eof_n;
  logic [23:0]   pix_n;
  logic [CW-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= PH0;
      res_q  <= '0;
      cnt_q  <= '0;
      eofp_q <= 1'b0;
      pix_q  <= '0;
      vld_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      sol_q  <= 1'b0;
      eol_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      eofp_q <= eofp_d;
      pix_q  <= pix_d;
      vld_q  <= vld_d;
      sof_q  <= sof_d;
      eof_q  <= eof_d;
      sol_q  <= sol_d;
      eol_q  <= eol_d;
      err_q  <= err_d;
    end
  end

  // A sop arriving mid-group restarts the group with this word as w0.
  always_comb begin
    ph_d   = ph_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    eofp_d = eofp_q;
    pix_d  = pix_q;
    vld_d  = vld_q;
    sof_d  = sof_q;
    eof_d  = eof_q;
    sol_d  = sol_q;
    eol_d  = eol_q;
    err_d  = 1'b0;
    new_px = 1'b0;
    sof_n  = 1'b0;
    eof_n  = 1'b0;
    pix_n  = '0;
    pc     = '0;
    resync = in_sop && ((ph_q == PH1) || (ph_q == PH2));
    eph    = resync ? PH0 : ph_q;

    if (ld) begin
      vld_d = 1'b0;
      sof_d = 1'b0;
      eof_d = 1'b0;
      sol_d = 1'b0;
      eol_d = 1'b0;
    end

    if ((ph_q == PH3) && ld) begin
      new_px = 1'b1;
      pix_n  = res_q;
      eof_n  = eofp_q;
      eofp_d = 1'b0;
      ph_d   = PH0;
    end else if (acc) begin
      new_px = 1'b1;
      err_d  = resync ||
               (in_eop && ((eph == PH0) || (eph == PH1)));
      unique case (eph)
        PH0: begin
          pix_n = in_data[23:0];
          res_d = {16'h0, in_data[31:24]};
          sof_n = in_sop;
          eof_n = in_eop;
          ph_d  = in_eop ? PH0 : PH1;
        end
        PH1: begin
          pix_n = {in_data[15:0], res_q[7:0]};
          res_d = {8'h0, in_data[31:16]};
          eof_n = in_eop;
          ph_d  = in_eop ? PH0 : PH2;
        end
        PH2: begin
          pix_n  = {in_data[7:0], res_q[15:0]};
          res_d  = in_data[31:8];
          eofp_d = in_eop;
          ph_d   = PH3;
        end
        default: ;
      endcase
    end

    if (new_px) begin
      pc    = sof_n ? '0 : cnt_q;
      cnt_d = (pc == LAST) ? '0 : pc + 1'b1;
      pix_d = pix_n;
      vld_d = 1'b1;
      sof_d = sof_n;
      eof_d = eof_n;
      sol_d = (pc == '0);
      eol_d = (pc == LAST);
    end
  end

  always_comb begin
    ld       = !vld_q || out_ready;
    in_ready = (ph_q != PH3) && ld;
    acc      = in_valid && in_ready;
  end

  assign out_pixel = pix_q;
  assign out_valid = vld_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_sol   = sol_q;
  assign out_eol   = eol_q;
  assign err_align = err_q;

endmodule

// File: tb/tb_stream_rgb888_unpacker.sv
// Directed bench for stream_rgb888_unpacker, 8-pixel lines.
// Inputs change and outputs are sampled on the falling edge.
module tb_stream_rgb888_unpacker;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [23:0] out_pixel;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_sol;
  logic        out_eol;
  logic        out_ready;
  logic        err_align;

  int n_vec;
  int n_err;

  stream_rgb888_unpacker #(.LINE_PIXELS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .out_ready (out_ready),
    .err_align (err_align)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'h0, out_valid, out_sof, out_eof, out_sol, out_eol};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic e);
    in_data  = d;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic px(input string tag, input logic [23:0] p,
                    input logic [4:0] f);
    check({tag, ".pix"}, {8'h0, out_pixel}, {8'h0, p});
    check({tag, ".flg"}, flags(), {27'h0, f});
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int          wi;
    int          pi;
    int          cyc;
    logic        acc;
    logic [23:0] ep;
    logic [4:0]  ef;

    n_vec     = 0;
    n_err     = 0;
    out_ready = 1'b1;
    idle();
    rst_n = 1'b0;
    #1;
    check("rst.pix", {8'h0, out_pixel}, 32'h0);
    check("rst.flg", flags(), 32'h0);
    check("rst.err", {31'h0, err_align}, 32'h0);
    check("rst.rdy", {31'h0, in_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst.rdy2", {31'h0, in_ready}, 32'h1);

    // flag order: valid, sof, eof, sol, eol
    drive(32'hDDCC_BBAA, 1'b1, 1'b0);
    tick();
    px("grp.p0", 24'hCCBBAA, 5'b11010);
    drive(32'h3322_1100, 1'b0, 1'b0);
    tick();
    px("grp.p1", 24'h1100DD, 5'b10000);
    drive(32'h6655_4433, 1'b0, 1'b1);
    tick();
    px("grp.p2", 24'h333322, 5'b10000);
    check("grp.rdy3", {31'h0, in_ready}, 32'h0);
    idle();
    tick();
    px("grp.p3", 24'h665544, 5'b10100);
    check("grp.rdy4", {31'h0, in_ready}, 32'h1);

    drive(32'hDDCC_BBAA, 1'b1, 1'b0);
    tick();
    px("bp.p0", 24'hCCBBAA, 5'b11010);
    drive(32'h3322_1100, 1'b0, 1'b0);
    tick();
    px("bp.p1", 24'h1100DD, 5'b10000);
    drive(32'h6655_4433, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      px("bp.hold", 24'h1100DD, 5'b10000);
      check("bp.rdy", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    px("bp.p2", 24'h333322, 5'b10000);
    idle();
    tick();
    px("bp.p3", 24'h665544, 5'b10100);

    // 9 words of byte-ramp data: pixel k is bytes 3k..3k+2
    do_reset();
    wi  = 0;
    pi  = 0;
    cyc = 0;
    drive(32'h0302_0100, 1'b1, 1'b0);
    while (pi < 12 && cyc < 40) begin
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        wi++;
        if (wi < 9)
          drive({8'(4*wi+3), 8'(4*wi+2), 8'(4*wi+1), 8'(4*wi)},
                1'b0, wi == 8);
        else
          idle();
      end
      if (out_valid) begin
        ep = {8'(3*pi+2), 8'(3*pi+1), 8'(3*pi)};
        ef = {1'b1, pi == 0, pi == 11, (pi % 8) == 0, (pi % 8) == 7};
        px($sformatf("line.%0d", pi), ep, ef);
        pi++;
      end
    end
    check("line.npix", pi, 12);
    check("line.cyc", cyc, 12);
    idle();

    do_reset();
    drive(32'h4433_2211, 1'b0, 1'b0);
    tick();
    px("mis.a", 24'h332211, 5'b10010);
    check("mis.err0", {31'h0, err_align}, 32'h0);
    drive(32'h8877_6655, 1'b1, 1'b0);
    tick();
    px("mis.b", 24'h776655, 5'b11010);
    check("mis.err1", {31'h0, err_align}, 32'h1);
    drive(32'hCCBB_AA99, 1'b0, 1'b0);
    tick();
    px("mis.c", 24'hAA9988, 5'b10000);
    check("mis.err2", {31'h0, err_align}, 32'h0);

    do_reset();
    drive(32'h0102_0304, 1'b1, 1'b0);
    tick();
    px("eop.p0", 24'h020304, 5'b11010);
    drive(32'h0506_0708, 1'b0, 1'b1);
    tick();
    px("eop.p1", 24'h070801, 5'b10100);
    check("eop.err", {31'h0, err_align}, 32'h1);
    check("eop.rdy", {31'h0, in_ready}, 32'h1);
    drive(32'h0A0B_0C0D, 1'b0, 1'b0);
    tick();
    px("eop.w0", 24'h0B0C0D, 5'b10000);
    check("eop.err2", {31'h0, err_align}, 32'h0);

    idle();
    tick();
    drive(32'h1111_1111, 1'b1, 1'b0);
    tick();
    drive(32'h2222_2222, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    check("mrst.pix", {8'h0, out_pixel}, 32'h0);
    check("mrst.flg", flags(), 32'h0);
    check("mrst.err", {31'h0, err_align}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst.rdy", {31'h0, in_ready}, 32'h1);
    drive(32'h00AB_CDEF, 1'b0, 1'b0);
    tick();
    px("mrst.w0", 24'hABCDEF, 5'b10010);

    do_reset();
    drive(32'h1234_5678, 1'b1, 1'b1);
    tick();
    px("se.p0", 24'h345678, 5'b11110);
    check("se.err", {31'h0, err_align}, 32'h1);
    idle();
    tick();
    check("se.err2", {31'h0, err_align}, 32'h0);
    check("se.rdy", {31'h0, in_ready}, 32'h1);
    check("se.vld", {31'h0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
